// File: rtl/scanline_fetch_arbiter.sv
// scanline_fetch_arbiter
// Shares one single-port frame SRAM between display line prefetch and an
// overlay writer. On each qualifying line start it streams the next visible
// line into one bank of a ping-pong line buffer; the writer gets every other
// cycle. SRAM strobes and wr_ack are registered.
module scanline_fetch_arbiter #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int V_TOTAL    = 525,
  parameter int LINE_WORDS = 80,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic [12:0]       hcnt,
  input  logic [12:0]       vcnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [7:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_overrun
);

  // Index counter must cover a full fetch and never be narrower than the
  // 7-bit word index carried into the line buffer address.
  localparam int SPAN  = (LINE_WORDS > H_VISIBLE / 8) ? LINE_WORDS : H_VISIBLE / 8;
  localparam int IDX_W = ($clog2(SPAN) > 7) ? $clog2(SPAN) : 7;
  localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  line_base;
  logic               fetch_bank;
  logic [IDX_W-1:0]   idx;
  logic [DRN_W-1:0]   drain_cnt;
  logic               trig_pend;

  logic               trig;
  logic               trig_last;
  logic               trig_vis;
  logic [ADDR_W-1:0]  base_nxt;
  logic               bank_nxt;

  logic [RD_LAT-1:0]  pipe_v;
  logic [RD_LAT-1:0]  pipe_bank;
  logic [6:0]         pipe_idx [RD_LAT];

  // Line-start trigger decode and the base/bank the triggered fetch will use.
  always_comb begin
    trig_last = (vcnt == 13'(V_TOTAL - 1));
    trig_vis  = (vcnt < 13'(V_VISIBLE - 1));
    trig      = (hcnt == '0) && (trig_last || trig_vis);
    base_nxt  = trig_last ? '0 : line_base + ADDR_W'(LINE_WORDS);
    bank_nxt  = trig_last ? 1'b0 : ~vcnt[0];
  end

  // Arbitration FSM with registered SRAM strobes, address, data and ack.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      line_base     <= '0;
      fetch_bank    <= 1'b0;
      idx           <= '0;
      drain_cnt     <= '0;
      trig_pend     <= 1'b0;
      wr_ack        <= 1'b0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      mem_wdata     <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      mem_wr <= 1'b0;

      if (trig) begin
        line_base  <= base_nxt;
        fetch_bank <= bank_nxt;
      end

      // A trigger while busy fetching aborts the fetch and restarts at idx 0;
      // reads already issued still land via the return pipeline.
      if (trig && (state == FETCH || state == DRAIN)) begin
        fetch_overrun <= 1'b1;
        state         <= FETCH;
        mem_rd        <= 1'b1;
        mem_addr      <= base_nxt;
        idx           <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trig || trig_pend) begin
              // A latched trigger already moved line_base to the new line.
              state     <= FETCH;
              trig_pend <= 1'b0;
              mem_rd    <= 1'b1;
              mem_addr  <= trig ? base_nxt : line_base;
              idx       <= '0;
            end else if (wr_req) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= wr_data;
              wr_ack    <= 1'b1;
            end
          end
          FETCH: begin
            if (idx == IDX_W'(LINE_WORDS - 1)) begin
              mem_rd    <= 1'b0;
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
              idx      <= idx + IDX_W'(1);
            end
          end
          DRAIN: begin
            if (drain_cnt == DRN_W'(RD_LAT - 1)) begin
              state <= IDLE;
            end else begin
              drain_cnt <= drain_cnt + DRN_W'(1);
            end
          end
          WRITE: begin
            state <= IDLE;
            if (trig) begin
              trig_pend <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            mem_rd <= 1'b0;
          end
        endcase
      end
    end
  end

  // Return pipeline: tags each issued read so its data lands RD_LAT later.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      pipe_v    <= '0;
      pipe_bank <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_v[0]    <= mem_rd;
      pipe_bank[0] <= mem_rd ? fetch_bank : 1'b0;
      pipe_idx[0]  <= mem_rd ? idx[6:0] : 7'd0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
    end
  end

  assign lb_we    = pipe_v[RD_LAT-1];
  assign lb_waddr = {pipe_bank[RD_LAT-1], pipe_idx[RD_LAT-1]};
  assign lb_wdata = lb_we ? mem_rdata : '0;

endmodule

// File: tb/tb_scanline_fetch_arbiter.sv
// Bench for scanline_fetch_arbiter: directed line-trigger vectors from a
// table, a full visible-line sweep, plus writer, overrun and reset sequences.
module tb_scanline_fetch_arbiter;

  localparam int LW = 80;
  localparam int RL = 2;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [12:0] hcnt, vcnt;
  logic        wr_req;
  logic [17:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack, mem_rd, mem_wr, lb_we, fetch_overrun;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, lb_wdata;
  logic [7:0]  lb_waddr;

  logic        o_wr_ack, o_mem_rd, o_mem_wr, o_lb_we, o_overrun;
  logic [17:0] o_mem_addr;
  logic [31:0] o_mem_wdata, o_lb_wdata;
  logic [31:0] o_mem_rdata = '0;
  logic [7:0]  o_lb_waddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 pixel_clk = ~pixel_clk;

  scanline_fetch_arbiter dut (
    .pixel_clk(pixel_clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .fetch_overrun(fetch_overrun)
  );

  scanline_fetch_arbiter #(.LINE_WORDS(900)) dut_ovr (
    .pixel_clk(pixel_clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(o_wr_ack),
    .mem_addr(o_mem_addr), .mem_rd(o_mem_rd), .mem_wr(o_mem_wr), .mem_wdata(o_mem_wdata),
    .mem_rdata(o_mem_rdata), .lb_we(o_lb_we), .lb_waddr(o_lb_waddr), .lb_wdata(o_lb_wdata),
    .fetch_overrun(o_overrun)
  );

  function automatic logic [31:0] fmem(input logic [17:0] a);
    return 32'hC0DE0000 ^ {14'd0, a};
  endfunction

  // SRAM model with two-cycle read latency.
  logic [31:0] sram_d1;
  always @(posedge pixel_clk) begin
    sram_d1   <= mem_rd ? fmem(mem_addr) : 32'd0;
    mem_rdata <= sram_d1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse(input int unsigned v);
    @(posedge pixel_clk); #1;
    vcnt = 13'(v);
    hcnt = 13'd0;
    @(posedge pixel_clk); #1;
    hcnt = 13'd1;
  endtask

  // Samples the LW read cycles plus RL drain cycles that follow a trigger.
  task automatic check_fetch(input int unsigned base, input logic bank);
    for (int i = 0; i < LW + RL; i++) begin
      @(negedge pixel_clk);
      if (i < LW)
        chk("fetch_rd", {44'd0, mem_rd, mem_wr, mem_addr}, {44'd0, 1'b1, 1'b0, 18'(base + i)});
      else
        chk("fetch_end", {62'd0, mem_rd, mem_wr}, 64'd0);
      if (i >= RL)
        chk("lb_write", {23'd0, lb_we, lb_waddr, lb_wdata},
            {23'd0, 1'b1, bank, 7'(i - RL), fmem(18'(base + i - RL))});
      else
        chk("lb_idle", {63'd0, lb_we}, 64'd0);
    end
  endtask

  typedef struct {
    int unsigned vcnt;
    bit          trig;
    int unsigned base;
    bit          bank;
  } line_vec_t;

  task automatic apply_line(input line_vec_t r);
    logic active;
    pulse(r.vcnt);
    if (r.trig) begin
      check_fetch(r.base, r.bank);
      chk("no_overrun", {63'd0, fetch_overrun}, 64'd0);
    end else begin
      active = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge pixel_clk);
        if (mem_rd || lb_we) active = 1'b1;
      end
      chk("no_trigger", {63'd0, active}, 64'd0);
    end
  endtask

  line_vec_t head [3];
  line_vec_t tail [5];

  initial begin
    int n_ack, ack_k;
    logic [17:0] ack_addr;
    logic found;

    head[0] = '{524, 1'b1, 0,     1'b0};
    head[1] = '{0,   1'b1, 80,    1'b1};
    head[2] = '{1,   1'b1, 160,   1'b0};
    tail[0] = '{478, 1'b1, 38320, 1'b1};
    tail[1] = '{479, 1'b0, 0,     1'b0};
    tail[2] = '{500, 1'b0, 0,     1'b0};
    tail[3] = '{523, 1'b0, 0,     1'b0};
    tail[4] = '{524, 1'b1, 0,     1'b0};

    rst = 1'b0; hcnt = 13'd1; vcnt = 13'd600;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge pixel_clk);
    chk("reset_outputs", {mem_rd, mem_wr, wr_ack, lb_we, fetch_overrun, mem_addr, lb_waddr, 33'd0},
        64'd0);
    chk("reset_data", {mem_wdata, lb_wdata}, 64'd0);
    rst = 1'b1;

    // Writer: held request served, then a changed request two cycles later.
    @(posedge pixel_clk); #1;
    wr_req = 1'b1; wr_addr = 18'h100; wr_data = 32'hDEADBEEF;
    @(negedge pixel_clk);
    chk("wr_not_yet", {62'd0, mem_wr, wr_ack}, 64'd0);
    @(negedge pixel_clk);
    chk("wr1", {11'd0, mem_wr, mem_rd, wr_ack, mem_addr, mem_wdata},
        {11'd0, 1'b1, 1'b0, 1'b1, 18'h100, 32'hDEADBEEF});
    @(posedge pixel_clk); #1;
    wr_addr = 18'h101; wr_data = 32'h12345678;
    @(negedge pixel_clk);
    chk("wr_gap", {62'd0, mem_wr, wr_ack}, 64'd0);
    @(negedge pixel_clk);
    chk("wr2", {11'd0, mem_wr, mem_rd, wr_ack, mem_addr, mem_wdata},
        {11'd0, 1'b1, 1'b0, 1'b1, 18'h101, 32'h12345678});
    @(posedge pixel_clk); #1;
    wr_req = 1'b0;
    repeat (2) begin
      @(negedge pixel_clk);
      chk("wr_done", {62'd0, mem_wr, wr_ack}, 64'd0);
    end

    // Line triggers: table head, sweep of every visible line, table tail.
    for (int i = 0; i < 3; i++) apply_line(head[i]);
    for (int v = 2; v < 478; v++) begin
      line_vec_t r;
      r = '{v, 1'b1, (v + 1) * LW, ~v[0]};
      apply_line(r);
    end
    for (int i = 0; i < 5; i++) apply_line(tail[i]);

    // Trigger and write request in the same cycle: fetch first, one ack after.
    @(posedge pixel_clk); #1;
    vcnt = 13'd0; hcnt = 13'd0;
    wr_req = 1'b1; wr_addr = 18'h2AA; wr_data = 32'hCAFEF00D;
    @(posedge pixel_clk); #1;
    hcnt = 13'd1;
    check_fetch(80, 1'b1);
    n_ack = 0; ack_k = -1; ack_addr = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pixel_clk);
      if (wr_ack) begin
        n_ack++;
        ack_k = k;
        ack_addr = mem_addr;
      end
      @(posedge pixel_clk); #1;
      if (n_ack > 0) wr_req = 1'b0;
    end
    chk("coll_ack_count", 64'(n_ack), 64'd1);
    chk("coll_ack_cycle", 64'(ack_k), 64'd1);
    chk("coll_ack_addr", {46'd0, ack_addr}, {46'd0, 18'h2AA});

    // Overrun with LINE_WORDS=900: second trigger lands mid-fetch.
    rst = 1'b0;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b1;
    pulse(524);
    for (int i = 0; i < 84; i++) begin
      @(negedge pixel_clk);
      if (i == 0 || i == 83)
        chk("ovr_rd", {45'd0, o_mem_rd, o_mem_addr}, {45'd0, 1'b1, 18'(i)});
    end
    chk("ovr_pre", {63'd0, o_overrun}, 64'd0);
    pulse(0);
    @(negedge pixel_clk);
    chk("ovr_flag", {62'd0, o_overrun, fetch_overrun}, {62'd0, 1'b1, 1'b0});
    chk("ovr_restart", {45'd0, o_mem_rd, o_mem_addr}, {45'd0, 1'b1, 18'd900});
    chk("ovr_old_land", {62'd0, o_lb_we, o_lb_waddr[7]}, {62'd0, 1'b1, 1'b0});
    @(negedge pixel_clk);
    chk("ovr_next", {46'd0, o_mem_addr}, {46'd0, 18'd901});
    chk("ovr_old_land2", {62'd0, o_lb_we, o_lb_waddr[7]}, {62'd0, 1'b1, 1'b0});
    @(negedge pixel_clk);
    chk("ovr_new_land", {55'd0, o_lb_we, o_lb_waddr}, {55'd0, 1'b1, 8'h80});

    // Reset asserted mid-fetch at idx 40.
    rst = 1'b0;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b1;
    pulse(524);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge pixel_clk);
      if (mem_rd && mem_addr == 18'd40) found = 1'b1;
    end
    chk("reach_idx40", {63'd0, found}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {mem_rd, mem_wr, wr_ack, lb_we, fetch_overrun, o_overrun, mem_addr, lb_waddr, 32'd0},
        64'd0);
    chk("rst_mid_data", {mem_wdata, lb_wdata}, 64'd0);
    repeat (2) @(negedge pixel_clk);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      if (mem_rd || mem_wr || lb_we) found = 1'b1;
    end
    chk("post_rst_quiet", {63'd0, found}, 64'd0);
    @(posedge pixel_clk); #1;
    wr_req = 1'b1; wr_addr = 18'h155; wr_data = 32'h0BADF00D;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    chk("post_rst_write", {11'd0, mem_wr, mem_rd, wr_ack, mem_addr, mem_wdata},
        {11'd0, 1'b1, 1'b0, 1'b1, 18'h155, 32'h0BADF00D});
    @(posedge pixel_clk); #1;
    wr_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
